// File: rtl/uart_frame_ctrl_pkg.sv
// Shared definitions for the UART frame-level controllers: FSM state encoding,
// error codes reported on err_code, and the default start-of-frame marker.
package uart_frame_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_LEN     = 2'b01,
      ST_PAYLOAD = 2'b10,
      ST_CHK     = 2'b11
   } state_t;

   localparam logic [1:0] ERR_LEN = 2'd1;
   localparam logic [1:0] ERR_CHK = 2'd2;
   localparam logic [1:0] ERR_TO  = 2'd3;

   localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// Byte-in / payload-out bundle of the frame controller. The controller takes the
// master side; the receiver, payload buffer and status consumer sit on the slave side.
interface uart_frame_ctrl_if #(
   parameter int AW = 4
);

   logic          s_tick;
   logic          rx_done_tick;
   logic [7:0]    rx_data;
   logic          pay_we;
   logic [AW-1:0] pay_addr;
   logic [7:0]    pay_data;
   logic          frame_done;
   logic [7:0]    frame_len;
   logic          frame_err;
   logic [1:0]    err_code;
   logic          busy;

   modport master (
      input  s_tick, rx_done_tick, rx_data,
      output pay_we, pay_addr, pay_data, frame_done, frame_len, frame_err, err_code, busy
   );

   modport slave (
      output s_tick, rx_done_tick, rx_data,
      input  pay_we, pay_addr, pay_data, frame_done, frame_len, frame_err, err_code, busy
   );

endinterface

// File: rtl/uart_timeout_cnt.sv
// Tick-qualified inactivity counter: clr holds it at zero, expire pulses on the
// tick that would take it past TIMEOUT_TICKS-1. Shared by the RX and TX controllers.
module uart_timeout_cnt #(
   parameter int TIMEOUT_TICKS = 640,
   parameter int TW            = $clog2(TIMEOUT_TICKS + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic tick,
   output logic expire
);

   logic [TW-1:0] tcnt;
   logic          at_limit;

   assign at_limit = (tcnt == TW'(TIMEOUT_TICKS - 1));
   // A clear in the same cycle suppresses expiry so a late byte always wins.
   assign expire   = tick && at_limit && !clr;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         tcnt <= '0;
      end else if (tick) begin
         tcnt <= at_limit ? '0 : tcnt + TW'(1);
      end
   end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser behind the UART receiver: SOF, LEN, PAYLOAD[LEN], CHK (XOR of LEN
// and payload). Payload is streamed to an external buffer; completion/error pulses follow.
module uart_frame_ctrl
   import uart_frame_ctrl_pkg::*;
#(
   parameter logic [7:0] SOF_BYTE      = SOF_BYTE_DEFAULT,
   parameter int         MAX_LEN       = 16,
   parameter int         TIMEOUT_TICKS = 640,
   parameter int         AW            = $clog2(MAX_LEN),
   parameter int         TW            = $clog2(TIMEOUT_TICKS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   uart_frame_ctrl_if.master bus
);

   state_t        state, state_n;
   logic [7:0]    len, len_n;
   logic [7:0]    chk, chk_n;
   logic [AW-1:0] idx, idx_n;

   logic          pay_we_r, pay_we_n;
   logic [AW-1:0] pay_addr_r, pay_addr_n;
   logic [7:0]    pay_data_r, pay_data_n;
   logic          done_r, done_n;
   logic [7:0]    frame_len_r, frame_len_n;
   logic          err_r, err_n;
   logic [1:0]    err_code_r, err_code_n;
   logic          busy_r;

   logic          to_clr;
   logic          to_expire;

   assign to_clr = bus.rx_done_tick || (state == ST_IDLE);

   uart_timeout_cnt #(
      .TIMEOUT_TICKS (TIMEOUT_TICKS),
      .TW            (TW)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clr    (to_clr),
      .tick   (bus.s_tick),
      .expire (to_expire)
   );

   always_comb begin
      state_n     = state;
      len_n       = len;
      chk_n       = chk;
      idx_n       = idx;
      pay_we_n    = 1'b0;
      pay_addr_n  = pay_addr_r;
      pay_data_n  = pay_data_r;
      done_n      = 1'b0;
      frame_len_n = frame_len_r;
      err_n       = 1'b0;
      err_code_n  = err_code_r;

      unique case (state)
         ST_IDLE: begin
            if (bus.rx_done_tick && (bus.rx_data == SOF_BYTE)) begin
               state_n = ST_LEN;
            end
         end

         ST_LEN: begin
            if (bus.rx_done_tick) begin
               len_n = bus.rx_data;
               chk_n = bus.rx_data;
               idx_n = '0;
               if (bus.rx_data > 8'(MAX_LEN)) begin
                  err_n      = 1'b1;
                  err_code_n = ERR_LEN;
                  state_n    = ST_IDLE;
               end else if (bus.rx_data == 8'd0) begin
                  state_n = ST_CHK;
               end else begin
                  state_n = ST_PAYLOAD;
               end
            end else if (to_expire) begin
               err_n      = 1'b1;
               err_code_n = ERR_TO;
               state_n    = ST_IDLE;
            end
         end

         // Bytes are written as they arrive; validity is only known at CHK.
         ST_PAYLOAD: begin
            if (bus.rx_done_tick) begin
               pay_we_n   = 1'b1;
               pay_addr_n = idx;
               pay_data_n = bus.rx_data;
               chk_n      = chk ^ bus.rx_data;
               if (8'(idx) == (len - 8'd1)) begin
                  state_n = ST_CHK;
               end else begin
                  idx_n = idx + AW'(1);
               end
            end else if (to_expire) begin
               err_n      = 1'b1;
               err_code_n = ERR_TO;
               state_n    = ST_IDLE;
            end
         end

         ST_CHK: begin
            if (bus.rx_done_tick) begin
               if (bus.rx_data == chk) begin
                  done_n      = 1'b1;
                  frame_len_n = len;
               end else begin
                  err_n      = 1'b1;
                  err_code_n = ERR_CHK;
               end
               state_n = ST_IDLE;
            end else if (to_expire) begin
               err_n      = 1'b1;
               err_code_n = ERR_TO;
               state_n    = ST_IDLE;
            end
         end

         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         len         <= '0;
         chk         <= '0;
         idx         <= '0;
         pay_we_r    <= 1'b0;
         pay_addr_r  <= '0;
         pay_data_r  <= '0;
         done_r      <= 1'b0;
         frame_len_r <= '0;
         err_r       <= 1'b0;
         err_code_r  <= '0;
         busy_r      <= 1'b0;
      end else begin
         state       <= state_n;
         len         <= len_n;
         chk         <= chk_n;
         idx         <= idx_n;
         pay_we_r    <= pay_we_n;
         pay_addr_r  <= pay_addr_n;
         pay_data_r  <= pay_data_n;
         done_r      <= done_n;
         frame_len_r <= frame_len_n;
         err_r       <= err_n;
         err_code_r  <= err_code_n;
         busy_r      <= (state_n != ST_IDLE);
      end
   end

   assign bus.pay_we     = pay_we_r;
   assign bus.pay_addr   = pay_addr_r;
   assign bus.pay_data   = pay_data_r;
   assign bus.frame_done = done_r;
   assign bus.frame_len  = frame_len_r;
   assign bus.frame_err  = err_r;
   assign bus.err_code   = err_code_r;
   assign bus.busy       = busy_r;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: directed frames plus random frames, each judged by a
// frame-level model (expected writes, XOR checksum, outcome) built from the byte list.
module tb_uart_frame_ctrl;
   import uart_frame_ctrl_pkg::*;

   localparam int         MAX_LEN       = 16;
   localparam int         TIMEOUT_TICKS = 640;
   localparam int         AW            = $clog2(MAX_LEN);
   localparam logic [7:0] SOF           = 8'hA5;

   logic clk = 1'b0;
   logic reset;

   uart_frame_ctrl_if #(.AW(AW)) bus ();

   uart_frame_ctrl #(
      .SOF_BYTE      (SOF),
      .MAX_LEN       (MAX_LEN),
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] m_len;
   logic [1:0] m_code;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic rt();
      return ($urandom_range(0, 1) == 1);
   endfunction

   // One clock of stimulus; returns #1 after the edge, ready for sampling.
   task automatic step(input logic rx, input logic [7:0] d, input logic tk);
      bus.rx_done_tick = rx;
      bus.rx_data      = d;
      bus.s_tick       = tk;
      @(posedge clk);
      #1;
      bus.rx_done_tick = 1'b0;
      bus.s_tick       = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic we, input logic [31:0] addr,
                             input logic [7:0] data, input logic done, input logic err,
                             input logic bsy);
      check({tag, " pay_we"}, 32'(bus.pay_we), 32'(we));
      if (we) begin
         check({tag, " pay_addr"}, 32'(bus.pay_addr), addr);
         check({tag, " pay_data"}, 32'(bus.pay_data), 32'(data));
      end
      check({tag, " frame_done"}, 32'(bus.frame_done), 32'(done));
      check({tag, " frame_err"}, 32'(bus.frame_err), 32'(err));
      check({tag, " busy"}, 32'(bus.busy), 32'(bsy));
      check({tag, " frame_len"}, 32'(bus.frame_len), 32'(m_len));
      check({tag, " err_code"}, 32'(bus.err_code), 32'(m_code));
   endtask

   task automatic gap(input int n, input logic bsy);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 8'h00, rt());
         expect_out("gap", 1'b0, 0, 8'h00, 1'b0, 1'b0, bsy);
      end
   endtask

   task automatic ticks(input int n, input logic bsy);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 8'h00, 1'b1);
         expect_out("tick", 1'b0, 0, 8'h00, 1'b0, 1'b0, bsy);
      end
   endtask

   task automatic send_frame(input string tag, input logic [7:0] len,
                             input logic [7:0] pl[$], input logic [7:0] chkb);
      logic [7:0] x;
      step(1'b1, SOF, rt());
      expect_out({tag, " sof"}, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
      gap($urandom_range(0, 3), 1'b1);
      step(1'b1, len, rt());
      if (int'(len) > MAX_LEN) begin
         m_code = ERR_LEN;
         expect_out({tag, " len"}, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);
         return;
      end
      expect_out({tag, " len"}, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
      x = len;
      for (int i = 0; i < int'(len); i++) begin
         gap($urandom_range(0, 3), 1'b1);
         step(1'b1, pl[i], rt());
         x = x ^ pl[i];
         expect_out({tag, " pay"}, 1'b1, i, pl[i], 1'b0, 1'b0, 1'b1);
      end
      gap($urandom_range(0, 3), 1'b1);
      step(1'b1, chkb, rt());
      if (chkb == x) begin
         m_len = len;
         expect_out({tag, " chk"}, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0);
      end else begin
         m_code = ERR_CHK;
         expect_out({tag, " chk"}, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);
      end
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] len, x, b;
      int         r;

      bus.rx_done_tick = 1'b0;
      bus.rx_data      = 8'h00;
      bus.s_tick       = 1'b0;
      reset            = 1'b1;
      m_len            = 8'h00;
      m_code           = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      expect_out("reset", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("reset pay_addr", 32'(bus.pay_addr), 0);
      check("reset pay_data", 32'(bus.pay_data), 0);
      reset = 1'b0;

      q = {};
      send_frame("zero", 8'h00, q, 8'h00);
      q = {8'h11, 8'h22, 8'h33};
      send_frame("good", 8'h03, q, 8'h03);

      q = {};
      send_frame("overlen", 8'h11, q, 8'h00);
      step(1'b1, 8'h01, 1'b0);
      expect_out("ign01", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h02, 1'b0);
      expect_out("ign02", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0);

      // Byte arriving on the expiring tick restarts the count instead of aborting.
      step(1'b1, SOF, 1'b0);
      expect_out("coin sof", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h04, 1'b0);
      expect_out("coin len", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h10, 1'b0);
      expect_out("coin p0", 1'b1, 0, 8'h10, 1'b0, 1'b0, 1'b1);
      ticks(TIMEOUT_TICKS - 1, 1'b1);
      step(1'b1, 8'h20, 1'b1);
      expect_out("coin p1", 1'b1, 1, 8'h20, 1'b0, 1'b0, 1'b1);
      ticks(TIMEOUT_TICKS - 1, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      m_code = ERR_TO;
      expect_out("coin to", 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);

      q = {8'hAA, 8'h55};
      send_frame("badchk", 8'h02, q, 8'h7F);

      step(1'b1, SOF, 1'b0);
      expect_out("to sof", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h04, 1'b0);
      expect_out("to len", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h10, 1'b0);
      expect_out("to p0", 1'b1, 0, 8'h10, 1'b0, 1'b0, 1'b1);
      ticks(TIMEOUT_TICKS - 1, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      m_code = ERR_TO;
      expect_out("to expire", 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);

      step(1'b1, SOF, 1'b0);
      expect_out("rst sof", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h04, 1'b0);
      expect_out("rst len", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h01, 1'b0);
      expect_out("rst p0", 1'b1, 0, 8'h01, 1'b0, 1'b0, 1'b1);
      reset = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      reset  = 1'b0;
      m_len  = 8'h00;
      m_code = 2'd0;
      expect_out("midrst", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("midrst pay_addr", 32'(bus.pay_addr), 0);
      check("midrst pay_data", 32'(bus.pay_data), 0);
      q = {8'h5A};
      send_frame("post", 8'h01, q, 8'h5B);

      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 3) == 0) begin
            b = 8'($urandom_range(0, 255));
            if (b == SOF) b = 8'h00;
            step(1'b1, b, rt());
            expect_out("noise", 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
         end
         r = $urandom_range(0, 9);
         q = {};
         if (r == 0) begin
            len = 8'($urandom_range(MAX_LEN + 1, 255));
            x   = 8'h00;
         end else begin
            len = 8'($urandom_range(0, MAX_LEN));
            x   = len;
            for (int i = 0; i < int'(len); i++) begin
               b = 8'($urandom_range(0, 255));
               q.push_back(b);
               x = x ^ b;
            end
            if (r <= 2) x = x ^ 8'($urandom_range(1, 255));
         end
         send_frame("rand", len, q, x);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
